// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM-stage port A and loader/debug port B share one memory.
// Latency: grant and memory strobes are combinational; ack and read data arrive one cycle later.
// Backpressure: a_stall holds the CPU off while B owns the memory; B waits at most STARVE_LIMIT cycles.
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata       CPU request; a_stall, a_ack, a_rdata back to the CPU
//   b_req/b_we/b_addr/b_wdata       loader/debug request; b_ack, b_rdata back to the loader
//   mem_addr/mem_wdata/mem_read/
//   mem_write, mem_rdata            data memory (combinational read)
//   grant_state                     registered last-cycle grant: 00 none, 01 A, 10 B, 11 B forced
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_stall,
    output logic        a_ack,
    output logic [31:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] b_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  grant_state
);

    // Counter must be able to hold STARVE_LIMIT itself; at least one bit wide.
    localparam int            CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    localparam logic [1:0] GS_NONE   = 2'b00;
    localparam logic [1:0] GS_A      = 2'b01;
    localparam logic [1:0] GS_B      = 2'b10;
    localparam logic [1:0] GS_FORCED = 2'b11;

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]    grant_state_q, grant_state_d;
    logic          a_ack_q, b_ack_q;
    logic [31:0]   a_rdata_q, a_rdata_d;
    logic [31:0]   b_rdata_q, b_rdata_d;

    logic forced;
    logic gnt_a;
    logic gnt_b;

    // B has waited its full allowance: it overrides A this cycle. With a
    // limit of zero this is true whenever B requests, so B always wins.
    assign forced = b_req & (wait_cnt_q == LIMIT);
    assign gnt_a  = ~reset & a_req & ~forced;
    assign gnt_b  = ~reset & b_req & (forced | ~a_req);

    assign a_stall = ~reset & a_req & ~gnt_a;

    always_comb begin
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (gnt_a) begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            mem_read  = ~a_we;
            mem_write = a_we;
        end else if (gnt_b) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_read  = ~b_we;
            mem_write = b_we;
        end
    end

    always_comb begin
        grant_state_d = GS_NONE;
        if (gnt_a) begin
            grant_state_d = GS_A;
        end else if (gnt_b) begin
            grant_state_d = forced ? GS_FORCED : GS_B;
        end
    end

    // Counts only cycles where B is actually left waiting.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!b_req || gnt_b) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    // Read data is captured on the grant edge so it is valid alongside ack;
    // writes leave the previous read data in place.
    always_comb begin
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (gnt_a && !a_we) begin
            a_rdata_d = mem_rdata;
        end
        if (gnt_b && !b_we) begin
            b_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            grant_state_q <= GS_NONE;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
            a_rdata_q     <= 32'h0;
            b_rdata_q     <= 32'h0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            grant_state_q <= grant_state_d;
            a_ack_q       <= gnt_a;
            b_ack_q       <= gnt_b;
            a_rdata_q     <= a_rdata_d;
            b_rdata_q     <= b_rdata_d;
        end
    end

    // A grant followed immediately by reset is treated as lost, so the
    // pending ack is masked while reset is high.
    assign a_ack       = a_ack_q & ~reset;
    assign b_ack       = b_ack_q & ~reset;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign grant_state = grant_state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 uses STARVE_LIMIT 4, instance 1 uses 0, both share inputs.
// Latency: outputs sampled on the falling edge, model advanced just before each rising edge.
// Backpressure: requesters modelled as hold-until-granted in directed cases, free-running in random.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;

    logic        a_stall [2];
    logic        a_ack   [2];
    logic        b_ack   [2];
    logic        mem_read  [2];
    logic        mem_write [2];
    logic [31:0] a_rdata [2];
    logic [31:0] b_rdata [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [1:0]  grant_state [2];

    logic [31:0] rom [16];
    logic [134:0] obs [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, per instance.
    int          lim  [2] = '{4, 0};
    int          wcnt [2];
    logic [1:0]  exp_gs   [2];
    logic        exp_aack [2];
    logic        exp_back [2];
    logic [31:0] exp_ard  [2];
    logic [31:0] exp_brd  [2];

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(4)) u_dut0 (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_stall(a_stall[0]), .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack[0]), .b_rdata(b_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .mem_rdata(mem_rdata[0]), .grant_state(grant_state[0])
    );

    dmem_arbiter #(.STARVE_LIMIT(0)) u_dut1 (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_stall(a_stall[1]), .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack[1]), .b_rdata(b_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .mem_rdata(mem_rdata[1]), .grant_state(grant_state[1])
    );

    // Memory: small combinational lookup table.
    assign mem_rdata[0] = rom[mem_addr[0][5:2]];
    assign mem_rdata[1] = rom[mem_addr[1][5:2]];

    for (genvar gi = 0; gi < 2; gi++) begin : g_obs
        assign obs[gi] = {grant_state[gi], a_ack[gi], b_ack[gi], a_stall[gi],
                          mem_read[gi], mem_write[gi], mem_addr[gi], mem_wdata[gi],
                          a_rdata[gi], b_rdata[gi]};
    end

    // Who gets the memory this cycle: 0 none, 1 A, 2 B, 3 B by starvation.
    function automatic int arb(int i);
        if (reset)                       return 0;
        if (b_req && wcnt[i] == lim[i])  return 3;
        if (a_req)                       return 1;
        if (b_req)                       return 2;
        return 0;
    endfunction

    function automatic logic [134:0] exp_vec(int i);
        int          g;
        logic [31:0] ma, mw;
        logic        rd, wr, st;
        g  = arb(i);
        ma = 32'h0; mw = 32'h0; rd = 1'b0; wr = 1'b0;
        if (g == 1) begin
            ma = a_addr; mw = a_wdata; rd = !a_we; wr = a_we;
        end else if (g >= 2) begin
            ma = b_addr; mw = b_wdata; rd = !b_we; wr = b_we;
        end
        st = a_req && (g != 1) && !reset;
        return {exp_gs[i], exp_aack[i] & !reset, exp_back[i] & !reset, st, rd, wr,
                ma, mw, exp_ard[i], exp_brd[i]};
    endfunction

    // Advance the model across the coming rising edge using current inputs.
    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            int g;
            g = arb(i);
            if (reset) begin
                wcnt[i] = 0; exp_gs[i] = 2'b00; exp_aack[i] = 1'b0; exp_back[i] = 1'b0;
                exp_ard[i] = 32'h0; exp_brd[i] = 32'h0;
            end else begin
                exp_gs[i]   = 2'(g);
                exp_aack[i] = (g == 1);
                exp_back[i] = (g >= 2);
                if (g == 1 && !a_we) exp_ard[i] = rom[a_addr[5:2]];
                if (g >= 2 && !b_we) exp_brd[i] = rom[b_addr[5:2]];
                if (!b_req || g >= 2)      wcnt[i] = 0;
                else if (wcnt[i] < lim[i]) wcnt[i] = wcnt[i] + 1;
            end
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        a_req = 1; a_we = 1; a_addr = 32'h8; b_req = 1; b_addr = 32'hC;
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== exp_vec(i)) begin
                n_bad++;
                $display("FAIL reset_vec inst%0d got %h want %h", i, obs[i], exp_vec(i));
            end
        end
        n_cmp++;
        if ({mem_write[0], mem_read[0], a_stall[0], grant_state[0], a_rdata[0]} !== 37'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got wr=%b rd=%b st=%b gs=%b ard=%h want all 0",
                     mem_write[0], mem_read[0], a_stall[0], grant_state[0], a_rdata[0]);
        end
        tick();
        reset = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_read();
        a_req = 1; a_we = 0; a_addr = 32'h4;
        @(negedge clk);
        n_cmp++;
        if ({mem_read[0], a_stall[0], mem_addr[0]} !== {1'b1, 1'b0, 32'h4}) begin
            n_bad++;
            $display("FAIL read_strobe got rd=%b st=%b addr=%h want 1 0 00000004",
                     mem_read[0], a_stall[0], mem_addr[0]);
        end
        tick();
        a_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({a_ack[0], a_rdata[0]} !== {1'b1, 32'h69}) begin
            n_bad++;
            $display("FAIL read_ack got ack=%b rdata=%h want 1 00000069", a_ack[0], a_rdata[0]);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== exp_vec(i)) begin
                n_bad++;
                $display("FAIL read_vec inst%0d got %h want %h", i, obs[i], exp_vec(i));
            end
        end
        tick();
    endtask

    task automatic test_both();
        a_req = 1; a_we = 0; a_addr = 32'h14; b_req = 1; b_we = 0; b_addr = 32'h18;
        @(negedge clk);
        n_cmp++;
        if ({a_stall[0], mem_addr[0]} !== {1'b0, 32'h14}) begin
            n_bad++;
            $display("FAIL both_a_first got st=%b addr=%h want 0 00000014", a_stall[0], mem_addr[0]);
        end
        tick();
        a_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({grant_state[0], a_ack[0], mem_addr[0]} !== {2'b01, 1'b1, 32'h18}) begin
            n_bad++;
            $display("FAIL both_b_next got gs=%b ack=%b addr=%h want 01 1 00000018",
                     grant_state[0], a_ack[0], mem_addr[0]);
        end
        tick();
        b_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({grant_state[0], b_ack[0], b_rdata[0]} !== {2'b10, 1'b1, rom[6]}) begin
            n_bad++;
            $display("FAIL both_b_ack got gs=%b ack=%b rdata=%h want 10 1 %h",
                     grant_state[0], b_ack[0], b_rdata[0], rom[6]);
        end
        tick();
    endtask

    task automatic test_starve();
        a_req = 1; a_we = 0; a_addr = 32'h20; b_req = 1; b_we = 0; b_addr = 32'h24;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (a_stall[0] !== (c == 5)) begin
                n_bad++;
                $display("FAIL starve_stall cyc%0d got %b want %b", c, a_stall[0], (c == 5));
            end
            n_cmp++;
            if ({a_stall[1], mem_addr[1]} !== {1'b1, 32'h24}) begin
                n_bad++;
                $display("FAIL strict_b cyc%0d got st=%b addr=%h want 1 00000024",
                         c, a_stall[1], mem_addr[1]);
            end
            if (c == 6) begin
                n_cmp++;
                if (grant_state[0] !== 2'b11) begin
                    n_bad++;
                    $display("FAIL starve_gs got %b want 11", grant_state[0]);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_b_write();
        logic [31:0] prev;
        @(negedge clk);
        prev = b_rdata[0];
        b_req = 1; b_we = 1; b_addr = 32'h4000_0010; b_wdata = 32'h0000_00FF;
        @(negedge clk);
        n_cmp++;
        if ({mem_write[0], mem_addr[0], mem_wdata[0]} !== {1'b1, 32'h4000_0010, 32'hFF}) begin
            n_bad++;
            $display("FAIL bwrite_strobe got wr=%b addr=%h data=%h want 1 40000010 000000ff",
                     mem_write[0], mem_addr[0], mem_wdata[0]);
        end
        tick();
        b_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({b_ack[0], b_rdata[0]} !== {1'b1, prev}) begin
            n_bad++;
            $display("FAIL bwrite_ack got ack=%b rdata=%h want 1 %h", b_ack[0], b_rdata[0], prev);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int first_b;
        a_req = 1; a_we = 1; a_addr = 32'h30; a_wdata = 32'hDEAD_BEEF;
        b_req = 1; b_we = 0; b_addr = 32'h34;
        for (int c = 0; c < 3; c++) tick();
        reset = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_write[0], a_ack[0], b_ack[0], a_stall[0]} !== 4'b0000) begin
                n_bad++;
                $display("FAIL rst_mid cyc%0d got wr=%b aack=%b back=%b st=%b want 0000",
                         c, mem_write[0], a_ack[0], b_ack[0], a_stall[0]);
            end
            tick();
        end
        reset = 0;
        first_b = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_cmp++;
                if (grant_state[0] !== 2'b00) begin
                    n_bad++;
                    $display("FAIL rst_mid_gs got %b want 00", grant_state[0]);
                end
            end
            if (first_b == 0 && mem_addr[0] == 32'h34) first_b = c;
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_vec(i)) begin
                    n_bad++;
                    $display("FAIL rst_mid_vec inst%0d got %h want %h", i, obs[i], exp_vec(i));
                end
            end
            tick();
        end
        // Counter cleared by reset: B must again wait through four A grants.
        n_cmp++;
        if (first_b != 5) begin
            n_bad++;
            $display("FAIL rst_mid_wait got first B grant cycle %0d want 5", first_b);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 3) begin
                a_req = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1);
                a_addr = {$urandom_range(0, 1) ? 4'h4 : 4'h0, 22'h0, 4'($urandom), 2'b00};
                a_wdata = $urandom;
            end
            if ($urandom_range(0, 9) < 2) begin
                b_req = $urandom_range(0, 1); b_we = $urandom_range(0, 1);
                b_addr = {28'h0, 4'($urandom)} << 2;
                b_wdata = $urandom;
            end
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_vec(i)) begin
                    n_bad++;
                    $display("FAIL random_vec inst%0d cyc%0d got %h want %h",
                             i, c, obs[i], exp_vec(i));
                end
            end
            tick();
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) rom[k] = $urandom;
        rom[1] = 32'h0000_0069;
        for (int i = 0; i < 2; i++) begin
            wcnt[i] = 0; exp_gs[i] = 2'b00; exp_aack[i] = 0; exp_back[i] = 0;
            exp_ard[i] = 32'h0; exp_brd[i] = 32'h0;
        end
        idle_inputs();
        reset = 1;
        #1;
        test_reset();
        test_read();
        test_both();
        test_starve();
        test_b_write();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
